// File: rtl/lab4_pkg.sv
// Shared types and default widths for the lab 4 engine scheduler.
package lab4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_C_RUN  = 3'd1,
      ST_C_REL  = 3'd2,
      ST_S_RUN  = 3'd3,
      ST_S_REL  = 3'd4,
      ST_REPORT = 3'd5
   } sched_state_t;

   localparam logic [1:0] MODE_NONE = 2'b00;
   localparam logic [1:0] MODE_CNT  = 2'b01;
   localparam logic [1:0] MODE_SRCH = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_CNT_W   = 4;
   localparam int DEF_LOC_W   = 5;
   localparam int DEF_TIMEOUT = 64;
   // Wide enough for the largest permitted TIMEOUT (255).
   localparam int TIMER_W     = 8;

endpackage

// File: rtl/engine_handshake.sv
// Level start/done handshake for one compute engine, with its own watchdog timer.
module engine_handshake
   import lab4_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic clock,
   input  logic reset_n,
   input  logic run,
   input  logic rel,
   input  logic done,
   output logic start,
   output logic enable,
   output logic captured,
   output logic released,
   output logic timed_out
);

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               at_limit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) timer_q <= '0;
      else          timer_q <= timer_d;
   end

   always_comb begin
      start     = run;
      enable    = run | rel;
      at_limit  = (timer_q == TIMER_W'(TIMEOUT - 1));
      captured  = run & done;
      released  = rel & ~done;
      // A done edge arriving on the last allowed cycle still wins over the watchdog.
      timed_out = ((run & ~done) | (rel & done)) & at_limit;
      timer_d   = '0;
      if ((run | rel) && !captured && !released && !timed_out)
         timer_d = timer_q + 1'b1;
   end

endmodule

// File: rtl/task_scheduler.sv
// Sequences the bit-counter and binary-search engines from one request and reports one result.
module task_scheduler
   import lab4_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int LOC_W   = DEF_LOC_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] a_in,
   output logic              cnt_start,
   output logic              cnt_enable,
   input  logic              cnt_done,
   input  logic [CNT_W-1:0]  cnt_result,
   output logic              srch_start,
   output logic              srch_enable,
   input  logic              srch_done,
   input  logic [LOC_W-1:0]  srch_loc,
   input  logic              srch_found,
   output logic [DATA_W-1:0] a_out,
   output logic              busy,
   output logic              valid,
   output logic [CNT_W-1:0]  count_q,
   output logic [LOC_W-1:0]  loc_q,
   output logic              found_q,
   output logic              timeout_err
);

   sched_state_t      state_q, state_d;
   logic              srch_after_q, srch_after_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [CNT_W-1:0]  count_d;
   logic [LOC_W-1:0]  loc_d;
   logic              found_d;
   logic              terr_q, terr_d;

   logic c_run, c_rel, s_run, s_rel;
   logic c_captured, c_released, c_timed_out;
   logic s_captured, s_released, s_timed_out;

   engine_handshake #(.TIMEOUT(TIMEOUT)) u_cnt_hs (
      .clock     (clock),
      .reset_n   (reset_n),
      .run       (c_run),
      .rel       (c_rel),
      .done      (cnt_done),
      .start     (cnt_start),
      .enable    (cnt_enable),
      .captured  (c_captured),
      .released  (c_released),
      .timed_out (c_timed_out)
   );

   engine_handshake #(.TIMEOUT(TIMEOUT)) u_srch_hs (
      .clock     (clock),
      .reset_n   (reset_n),
      .run       (s_run),
      .rel       (s_rel),
      .done      (srch_done),
      .start     (srch_start),
      .enable    (srch_enable),
      .captured  (s_captured),
      .released  (s_released),
      .timed_out (s_timed_out)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         srch_after_q <= 1'b0;
         a_q          <= '0;
         count_q      <= '0;
         loc_q        <= '0;
         found_q      <= 1'b0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         srch_after_q <= srch_after_d;
         a_q          <= a_d;
         count_q      <= count_d;
         loc_q        <= loc_d;
         found_q      <= found_d;
         terr_q       <= terr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      srch_after_d = srch_after_q;
      a_d          = a_q;
      count_d      = count_q;
      loc_d        = loc_q;
      found_d      = found_q;
      terr_d       = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (req && (mode != MODE_NONE)) begin
               a_d          = a_in;
               srch_after_d = mode[1];
               count_d      = '0;
               loc_d        = '0;
               found_d      = 1'b0;
               terr_d       = 1'b0;
               state_d      = mode[0] ? ST_C_RUN : ST_S_RUN;
            end
         end
         ST_C_RUN: begin
            if (c_captured) begin
               count_d = cnt_result;
               state_d = ST_C_REL;
            end else if (c_timed_out) begin
               terr_d  = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_C_REL: begin
            if (c_released) begin
               state_d = srch_after_q ? ST_S_RUN : ST_REPORT;
            end else if (c_timed_out) begin
               terr_d  = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_S_RUN: begin
            if (s_captured) begin
               loc_d   = srch_loc;
               found_d = srch_found;
               state_d = ST_S_REL;
            end else if (s_timed_out) begin
               terr_d  = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_S_REL: begin
            if (s_released) begin
               state_d = ST_REPORT;
            end else if (s_timed_out) begin
               terr_d  = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Engine controls decode straight from the state register, so reset drops them at once.
   always_comb begin
      c_run       = (state_q == ST_C_RUN);
      c_rel       = (state_q == ST_C_REL);
      s_run       = (state_q == ST_S_RUN);
      s_rel       = (state_q == ST_S_REL);
      valid       = (state_q == ST_REPORT);
      busy        = (state_q != ST_IDLE);
      a_out       = a_q;
      timeout_err = terr_q;
   end

endmodule

// File: tb/tb_task_scheduler.sv
// Scoreboard bench for task_scheduler with behavioural bit-counter and search engines.
module tb_task_scheduler;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] a_in = 8'h00;
   logic       cnt_start, cnt_enable;
   logic       cnt_done = 1'b0;
   logic [3:0] cnt_result = 4'h0;
   logic       srch_start, srch_enable;
   logic       srch_done = 1'b0;
   logic [4:0] srch_loc = 5'h00;
   logic       srch_found = 1'b0;
   logic [7:0] a_out;
   logic       busy, valid;
   logic [3:0] count_q;
   logic [4:0] loc_q;
   logic       found_q, timeout_err;

   task_scheduler #(.DATA_W(8), .CNT_W(4), .LOC_W(5), .TIMEOUT(64)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req         (req),
      .mode        (mode),
      .a_in        (a_in),
      .cnt_start   (cnt_start),
      .cnt_enable  (cnt_enable),
      .cnt_done    (cnt_done),
      .cnt_result  (cnt_result),
      .srch_start  (srch_start),
      .srch_enable (srch_enable),
      .srch_done   (srch_done),
      .srch_loc    (srch_loc),
      .srch_found  (srch_found),
      .a_out       (a_out),
      .busy        (busy),
      .valid       (valid),
      .count_q     (count_q),
      .loc_q       (loc_q),
      .found_q     (found_q),
      .timeout_err (timeout_err)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      logic [3:0] cnt;
      logic [4:0] loc;
      logic       found;
      logic       terr;
      logic [7:0] a;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Engine models: done follows start with a registered lag of cnt_lat/srch_lat cycles.
   int cnt_lat = 1, srch_lat = 1;
   bit cnt_never = 0, srch_never = 0;
   int cnt_ctr = 0, srch_ctr = 0;
   bit cnt_pend = 0, srch_pend = 0;

   initial forever begin
      @(negedge clock);
      cnt_done = cnt_pend;
      if (cnt_start) cnt_ctr++; else cnt_ctr = 0;
      cnt_pend = !cnt_never && cnt_start && (cnt_ctr >= cnt_lat);
      srch_done = srch_pend;
      if (srch_start) srch_ctr++; else srch_ctr = 0;
      srch_pend = !srch_never && srch_start && (srch_ctr >= srch_lat);
   end

   int cyc = 0;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   int         req_cyc = 0, last_lat = 0;
   int         valid_cnt = 0, overlap = 0, srch_en_seen = 0, srch_start_cnt = 0, a_bad = 0;
   logic [7:0] cur_a = 8'h00;
   bit         srch_seen = 0;
   logic [3:0] cnt_at_srch = 4'h0;
   logic [4:0] loc_at_srch = 5'h00;

   initial forever begin
      @(negedge clock);
      if (reset_n) begin
         if (cnt_enable && srch_enable) overlap++;
         if (srch_enable) srch_en_seen++;
         if (srch_start) srch_start_cnt++;
         if (srch_start && !srch_seen) begin
            srch_seen   = 1;
            cnt_at_srch = count_q;
            loc_at_srch = loc_q;
         end
         if (busy && (a_out !== cur_a)) a_bad++;
         if (valid) begin
            valid_cnt++;
            last_lat = cyc - req_cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("count_q", count_q, e.cnt);
               chk("loc_q", loc_q, e.loc);
               chk("found_q", found_q, e.found);
               chk("timeout_err", timeout_err, e.terr);
               chk("a_out", a_out, e.a);
            end
         end
      end
   end

   task automatic push_exp(input logic [3:0] c, input logic [4:0] l, input logic f,
                           input logic t, input logic [7:0] a);
      exp_t e;
      e.cnt = c; e.loc = l; e.found = f; e.terr = t; e.a = a;
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input logic [1:0] m, input logic [7:0] a);
      @(negedge clock);
      req = 1'b1; mode = m; a_in = a;
      req_cyc = cyc + 1;
      @(negedge clock);
      req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk(tag, busy, 1'b0);
      @(negedge clock);
   endtask

   function automatic logic [31:0] all_outs();
      return {cnt_start, cnt_enable, srch_start, srch_enable, a_out, busy, valid,
              count_q, loc_q, found_q, timeout_err};
   endfunction

   int v0;

   initial begin
      repeat (2) @(negedge clock);
      chk("reset_outputs", all_outs(), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_after_reset", all_outs(), 32'd0);

      // Count only, slow engine.
      cnt_lat = 9; cnt_result = 4'($countones(8'hB5));
      v0 = valid_cnt; srch_en_seen = 0;
      cur_a = 8'hB5; push_exp(4'd5, 5'd0, 1'b0, 1'b0, 8'hB5);
      drive_req(2'b01, 8'hB5);
      chk("busy_after_req", busy, 1'b1);
      wait_idle("m01_done");
      chk("m01_valids", valid_cnt - v0, 1);
      chk("m01_no_srch_en", srch_en_seen, 0);

      // Latency with one-cycle engines.
      cnt_lat = 1; cnt_result = 4'($countones(8'h0F));
      cur_a = 8'h0F; push_exp(4'd4, 5'd0, 1'b0, 1'b0, 8'h0F);
      drive_req(2'b01, 8'h0F);
      wait_idle("lat01_done");
      chk("lat_mode01", last_lat, 4);

      srch_lat = 1; srch_loc = 5'd9; srch_found = 1'b0;
      cur_a = 8'h33; push_exp(4'd0, 5'd9, 1'b0, 1'b0, 8'h33);
      drive_req(2'b10, 8'h33);
      wait_idle("lat10_done");
      chk("lat_mode10", last_lat, 4);

      // Count then search.
      cnt_lat = 2; cnt_result = 4'($countones(8'h2A));
      srch_lat = 3; srch_loc = 5'd17; srch_found = 1'b1;
      v0 = valid_cnt; overlap = 0; srch_seen = 0;
      cur_a = 8'h2A; push_exp(4'd3, 5'd17, 1'b1, 1'b0, 8'h2A);
      drive_req(2'b11, 8'h2A);
      wait_idle("m11_done");
      chk("m11_valids", valid_cnt - v0, 1);
      chk("m11_overlap", overlap, 0);
      chk("m11_cnt_before_srch", cnt_at_srch, 4'd3);
      chk("m11_loc_before_srch", loc_at_srch, 5'd0);

      // Search engine never answers.
      srch_never = 1; srch_start_cnt = 0; v0 = valid_cnt;
      cur_a = 8'h44; push_exp(4'd0, 5'd0, 1'b0, 1'b1, 8'h44);
      drive_req(2'b10, 8'h44);
      wait_idle("tmo_done");
      chk("tmo_start_cycles", srch_start_cnt, 64);
      chk("tmo_valids", valid_cnt - v0, 1);
      chk("tmo_sticky", timeout_err, 1'b1);
      chk("tmo_start_low", srch_start, 1'b0);
      srch_never = 0;

      // Second request while busy is dropped.
      cnt_lat = 9; cnt_result = 4'($countones(8'h3C)); v0 = valid_cnt; a_bad = 0;
      cur_a = 8'h3C; push_exp(4'd4, 5'd0, 1'b0, 1'b0, 8'h3C);
      drive_req(2'b01, 8'h3C);
      chk("terr_cleared", timeout_err, 1'b0);
      @(negedge clock);
      drive_req(2'b10, 8'hFF);
      chk("busy_a_held", a_out, 8'h3C);
      wait_idle("busyreq_done");
      chk("busyreq_valids", valid_cnt - v0, 1);
      chk("busyreq_a_out", a_out, 8'h3C);
      chk("a_stable", a_bad, 0);

      // Asynchronous reset in the middle of C_RUN.
      cnt_lat = 9; cur_a = 8'h77;
      drive_req(2'b01, 8'h77);
      @(negedge clock);
      chk("crun_before_rst", cnt_start, 1'b1);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      srch_lat = 2; srch_loc = 5'd3; srch_found = 1'b1; v0 = valid_cnt;
      cur_a = 8'h5A; push_exp(4'd0, 5'd3, 1'b1, 1'b0, 8'h5A);
      drive_req(2'b10, 8'h5A);
      wait_idle("post_rst_done");
      chk("post_rst_valids", valid_cnt - v0, 1);

      // Mode 00 is a no-op.
      v0 = valid_cnt;
      drive_req(2'b00, 8'h11);
      chk("nop_busy0", busy, 1'b0);
      repeat (5) @(negedge clock);
      chk("nop_busy1", busy, 1'b0);
      chk("nop_valids", valid_cnt - v0, 0);
      chk("nop_a_out", a_out, 8'h5A);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
